ac_alu: RTL and testbench
=========================

# ac_alu

Accumulator stage with integrated ALU and E (extended-carry) flip-flop, directly downstream of the data register: it consumes the 16-bit DR value and the 8-bit input register INPR and updates AC/E once per clock according to one-hot micro-operation strobes from the control unit. AC drives the common bus and the skip-condition logic (AC sign and zero) used by SPA/SNA/SZA. All state updates are single-cycle register transfers. No multi-cycle sequencing lives here.

## Interface
- WIDTH, 16, data width of AC and DR
- INW, 8, width of INPR
- CLK  input  1  system clock, all state changes on rising edge
- CLR  input  1  reset, asynchronous, active-high; forces AC=0, E=0
- DR  input  WIDTH  operand from data register
- INPR  input  INW  character from input register
- AND  input  1  AC <= AC & DR
- ADD  input  1  {E,AC} <= AC + DR
- LDA  input  1  AC <= DR
- INP  input  1  AC[INW-1:0] <= INPR, upper AC bits held
- COM  input  1  AC <= ~AC
- SHR  input  1  circulate right through E: AC <= {E, AC[WIDTH-1:1]}, E <= AC[0]
- SHL  input  1  circulate left through E: AC <= {AC[WIDTH-2:0], E}, E <= AC[WIDTH-1]
- INR  input  1  AC <= AC + 1, modulo 2^WIDTH, E unaffected
- CLRAC  input  1  synchronous clear, AC <= 0
- CLE  input  1  E <= 0
- CME  input  1  E <= ~E
- AC  output  WIDTH  accumulator register
- E  output  1  extended-carry flip-flop
- AC_ZERO  output  1  1 when AC == 0, combinational from AC register
- AC_NEG  output  1  AC[WIDTH-1]

## Operation
- Strobes are nominally one-hot. When several AC strobes are asserted together, exactly one AC op executes, chosen by fixed priority: CLRAC > LDA > AND > ADD > INP > COM > SHR > SHL > INR.
- No AC strobe asserted: AC holds.
- E update priority: the E effect of the winning AC op (ADD carry-out, SHR AC[0], SHL AC[WIDTH-1]) > CLE > CME > hold.
- A losing ADD/SHR/SHL has no effect on E.
- CLE/CME combine with a non-E AC op (e.g. COM+CME): both execute in the same cycle.
- ADD: full WIDTH+1-bit sum of AC and DR. E takes bit WIDTH (the carry). Incoming E is not added.
- INR: wraps 16'hFFFF -> 16'h0000 with no carry into E.
- SHR/SHL use the pre-edge values of E and AC (a true rotate through WIDTH+1 bits).
- INP: loads the low INW bits only. AC[WIDTH-1:INW] is unchanged.
- AC_ZERO and AC_NEG are decoded from the registered AC and carry no extra state.

## Timing
- Latency: 1 cycle. Strobes sampled at rising CLK; new AC/E are visible after that edge. AC_ZERO/AC_NEG are valid in the same cycle as the new AC.
- DR and INPR are sampled at the same edge as the strobe. DR loaded on edge N is usable by an AC op strobed at edge N+1.
- Reset values: AC=0, E=0, AC_ZERO=1, AC_NEG=0.
- CLR asserted mid-operation overrides any strobe immediately, without waiting for CLK. While CLR is high, all strobes are ignored.
- After CLR deasserts, the first rising edge executes normally.
- Back-to-back strobes on consecutive cycles are legal. Each operates on the previous cycle's result.

## Test plan
- Reset: drive CLR=1 with ADD=1 and DR=16'h1234 -> AC=0000, E=0, AC_ZERO=1 asynchronously. Release, then LDA with DR=16'h8001 -> AC=8001, AC_NEG=1, AC_ZERO=0.
- Add with carry: AC=FFFF, E=0; ADD with DR=0002 -> AC=0001, E=1. Next cycle ADD with DR=0001 -> AC=0002, E=0 (incoming E not added).
- Rotate: AC=8001, E=0; SHL -> AC=0002, E=1. Then SHR -> AC=8001, E=0.
- INP/COM/INR/AND: AC=ABCD; INP with INPR=5A -> AC=AB5A. COM -> 54A5. AND with DR=0FF0 -> 04A0. LDA FFFF then INR -> 0000, AC_ZERO=1, E unchanged.
- Priority:
  - CLRAC+LDA+CME with AC=1234, E=0 -> AC=0000, E=1.
  - ADD+CLE with AC=FFFF, DR=0001 -> AC=0000, E=1 (carry beats CLE).
  - LDA+SHR with DR=00F0, E=1 -> AC=00F0, E=1 (losing SHR leaves E unchanged).
- Hold: no strobes for 5 cycles with DR toggling -> AC and E constant.

Source files
------------

// File: rtl/ac_alu.sv
// Accumulator stage with ALU and extended-carry flip-flop E.
// One micro-operation per clock, selected by fixed priority among the strobes.
module ac_alu #(
    parameter int WIDTH = 16,
    parameter int INW   = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] DR,
    input  logic [INW-1:0]   INPR,
    input  logic             AND,
    input  logic             ADD,
    input  logic             LDA,
    input  logic             INP,
    input  logic             COM,
    input  logic             SHR,
    input  logic             SHL,
    input  logic             INR,
    input  logic             CLRAC,
    input  logic             CLE,
    input  logic             CME,
    output logic [WIDTH-1:0] AC,
    output logic             E,
    output logic             AC_ZERO,
    output logic             AC_NEG
);

    logic [WIDTH-1:0] r_ac;
    logic             r_e;
    logic [WIDTH-1:0] w_ac_next;
    logic             w_e_next;
    logic [WIDTH:0]   w_sum;

    // Incoming E is deliberately not part of the sum; E only receives the carry.
    assign w_sum = {1'b0, r_ac} + {1'b0, DR};

    always_comb begin
        w_ac_next = r_ac;
        w_e_next  = r_e;
        if (CLE) begin
            w_e_next = 1'b0;
        end else if (CME) begin
            w_e_next = ~r_e;
        end

        // The winning AC op may override the CLE/CME effect on E below.
        if (CLRAC) begin
            w_ac_next = '0;
        end else if (LDA) begin
            w_ac_next = DR;
        end else if (AND) begin
            w_ac_next = r_ac & DR;
        end else if (ADD) begin
            w_ac_next = w_sum[WIDTH-1:0];
            w_e_next  = w_sum[WIDTH];
        end else if (INP) begin
            w_ac_next = {r_ac[WIDTH-1:INW], INPR};
        end else if (COM) begin
            w_ac_next = ~r_ac;
        end else if (SHR) begin
            w_ac_next = {r_e, r_ac[WIDTH-1:1]};
            w_e_next  = r_ac[0];
        end else if (SHL) begin
            w_ac_next = {r_ac[WIDTH-2:0], r_e};
            w_e_next  = r_ac[WIDTH-1];
        end else if (INR) begin
            w_ac_next = r_ac + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_ac <= '0;
            r_e  <= 1'b0;
        end else begin
            r_ac <= w_ac_next;
            r_e  <= w_e_next;
        end
    end

    assign AC      = r_ac;
    assign E       = r_e;
    assign AC_ZERO = (r_ac == '0);
    assign AC_NEG  = r_ac[WIDTH-1];

endmodule

// File: tb/tb_ac_alu.sv
// Directed and randomized checks of ac_alu against an arithmetic reference model.
module tb_ac_alu;

    localparam logic [10:0] M_AND   = 11'd1;
    localparam logic [10:0] M_ADD   = 11'd2;
    localparam logic [10:0] M_LDA   = 11'd4;
    localparam logic [10:0] M_INP   = 11'd8;
    localparam logic [10:0] M_COM   = 11'd16;
    localparam logic [10:0] M_SHR   = 11'd32;
    localparam logic [10:0] M_SHL   = 11'd64;
    localparam logic [10:0] M_INR   = 11'd128;
    localparam logic [10:0] M_CLRAC = 11'd256;
    localparam logic [10:0] M_CLE   = 11'd512;
    localparam logic [10:0] M_CME   = 11'd1024;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] DR;
    logic [7:0]  INPR;
    logic [10:0] st;
    logic [15:0] AC;
    logic        E, AC_ZERO, AC_NEG;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ac;
    int m_e;

    always #5 CLK = ~CLK;

    ac_alu #(.WIDTH(16), .INW(8)) dut (
        .CLK(CLK), .CLR(CLR), .DR(DR), .INPR(INPR),
        .AND(st[0]), .ADD(st[1]), .LDA(st[2]), .INP(st[3]), .COM(st[4]),
        .SHR(st[5]), .SHL(st[6]), .INR(st[7]), .CLRAC(st[8]), .CLE(st[9]), .CME(st[10]),
        .AC(AC), .E(E), .AC_ZERO(AC_ZERO), .AC_NEG(AC_NEG)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: AC and E as plain integers, next value from the priority rules.
    task automatic model_step(input logic [10:0] s, input logic [15:0] dr, input logic [7:0] inpr);
        int a, e, d;
        a = m_ac; e = m_e; d = int'(dr);
        if (s & M_CLE) e = 0;
        else if (s & M_CME) e = 1 - m_e;
        if (s & M_CLRAC) a = 0;
        else if (s & M_LDA) a = d;
        else if (s & M_AND) a = m_ac & d;
        else if (s & M_ADD) begin
            a = (m_ac + d) % 65536;
            e = (m_ac + d) / 65536;
        end
        else if (s & M_INP) a = (m_ac / 256) * 256 + int'(inpr);
        else if (s & M_COM) a = 65535 - m_ac;
        else if (s & M_SHR) begin
            a = m_e * 32768 + m_ac / 2;
            e = m_ac % 2;
        end
        else if (s & M_SHL) begin
            a = (m_ac * 2) % 65536 + m_e;
            e = m_ac / 32768;
        end
        else if (s & M_INR) a = (m_ac + 1) % 65536;
        m_ac = a; m_e = e;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ac"},   32'(AC),      32'(m_ac));
        check({tag, ".e"},    32'(E),       32'(m_e));
        check({tag, ".zero"}, 32'(AC_ZERO), 32'(m_ac == 0));
        check({tag, ".neg"},  32'(AC_NEG),  32'(m_ac >= 32768));
    endtask

    task automatic step(input string tag, input logic [10:0] s, input logic [15:0] dr, input logic [7:0] inpr);
        st = s; DR = dr; INPR = inpr;
        model_step(s, dr, inpr);
        @(posedge CLK);
        #1;
        st = '0;
        check_model(tag);
        $display("[TB] %s strobes=%b DR=%h INPR=%h -> AC=%h E=%b", tag, s, dr, inpr, AC, E);
        @(negedge CLK);
    endtask

    initial begin
        CLR = 1'b1; st = '0; DR = '0; INPR = '0;
        m_ac = 0; m_e = 0;
        repeat (2) @(negedge CLK);
        check("rst.ac", 32'(AC), 32'h0);
        check("rst.e", 32'(E), 32'h0);
        check("rst.zero", 32'(AC_ZERO), 32'h1);
        check("rst.neg", 32'(AC_NEG), 32'h0);
        CLR = 1'b0;

        step("lda8001", M_LDA, 16'h8001, 8'h00);
        check("lda8001.lit", 32'(AC), 32'h8001);
        check("lda8001.neg", 32'(AC_NEG), 32'h1);
        check("lda8001.zero", 32'(AC_ZERO), 32'h0);

        // Asynchronous clear while ADD is strobed, with AC and E both nonzero.
        step("pre_ffff", M_LDA, 16'hFFFF, 8'h00);
        step("pre_add", M_ADD, 16'h0001, 8'h00);
        step("pre_5555", M_LDA, 16'h5555, 8'h00);
        #2; st = M_ADD; DR = 16'h1234;
        #1; CLR = 1'b1;
        #1;
        m_ac = 0; m_e = 0;
        check("aclr.ac", 32'(AC), 32'h0);
        check("aclr.e", 32'(E), 32'h0);
        check("aclr.zero", 32'(AC_ZERO), 32'h1);
        @(posedge CLK); #1;
        check("aclr_hold.ac", 32'(AC), 32'h0);
        @(negedge CLK);
        CLR = 1'b0; st = '0;

        step("add_setup", M_LDA | M_CLE, 16'hFFFF, 8'h00);
        step("add_carry", M_ADD, 16'h0002, 8'h00);
        check("add_carry.lit", {15'd0, E, AC}, 32'h1_0001);
        step("add_noein", M_ADD, 16'h0001, 8'h00);
        check("add_noein.lit", {15'd0, E, AC}, 32'h0_0002);

        step("rot_setup", M_LDA | M_CLE, 16'h8001, 8'h00);
        step("shl", M_SHL, 16'h0000, 8'h00);
        check("shl.lit", {15'd0, E, AC}, 32'h1_0002);
        step("shr", M_SHR, 16'h0000, 8'h00);
        check("shr.lit", {15'd0, E, AC}, 32'h0_8001);

        step("lda_abcd", M_LDA, 16'hABCD, 8'h00);
        step("inp", M_INP, 16'h0000, 8'h5A);
        check("inp.lit", 32'(AC), 32'hAB5A);
        step("com", M_COM, 16'h0000, 8'h00);
        check("com.lit", 32'(AC), 32'h54A5);
        step("and", M_AND, 16'h0FF0, 8'h00);
        check("and.lit", 32'(AC), 32'h04A0);
        step("lda_ffff_cme", M_LDA | M_CME, 16'hFFFF, 8'h00);
        step("inr_wrap", M_INR, 16'h0000, 8'h00);
        check("inr_wrap.lit", {15'd0, E, AC}, 32'h1_0000);
        check("inr_wrap.zero", 32'(AC_ZERO), 32'h1);

        step("pri_setup", M_LDA | M_CLE, 16'h1234, 8'h00);
        step("pri_clrac", M_CLRAC | M_LDA | M_CME, 16'h5678, 8'h00);
        check("pri_clrac.lit", {15'd0, E, AC}, 32'h1_0000);
        step("pri_setup2", M_LDA, 16'hFFFF, 8'h00);
        step("pri_addcle", M_ADD | M_CLE, 16'h0001, 8'h00);
        check("pri_addcle.lit", {15'd0, E, AC}, 32'h1_0000);
        step("pri_ldashr", M_LDA | M_SHR, 16'h00F0, 8'h00);
        check("pri_ldashr.lit", {15'd0, E, AC}, 32'h1_00F0);

        for (int i = 0; i < 5; i++) begin
            step("hold", 11'd0, 16'($urandom), 8'($urandom));
            check("hold.lit", {15'd0, E, AC}, 32'h1_00F0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [10:0] s;
            case ($urandom_range(0, 3))
                0: s = 11'($urandom);
                1: s = 11'd0;
                default: s = 11'(32'd1 << $urandom_range(0, 10));
            endcase
            step("rand", s, 16'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
